// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: size codes, FSM states and width helpers for mem_access_unit
package mem_access_unit_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;
    localparam int SIZE_BYTE = 0;
    localparam int SIZE_HALF = 1;
    localparam int SIZE_WORD = 2;
    function automatic int sz_w(input int nl);
        return ($clog2($clog2(nl) + 1) < 1) ? 1 : $clog2($clog2(nl) + 1);
    endfunction
endpackage

// File: rtl/lane_extend.sv
// lane_extend: sign/zero extension of the low n lanes of data to the full DATA_W width
module lane_extend #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    localparam int NL = DATA_W / LANE_W,
    localparam int CW = $clog2(NL) + 1
) (
    input  logic [DATA_W-1:0] data,
    input  logic [CW-1:0]     n,
    input  logic              sext,
    output logic [DATA_W-1:0] ext
);
    logic fill;
    always_comb begin
        fill = 1'b0;
        ext = '0;
        for (int i = 0; i < NL; i++)
            if (int'(n) == i + 1) fill = sext & data[i*LANE_W + LANE_W-1];
        for (int i = 0; i < NL; i++)
            ext[i*LANE_W +: LANE_W] = (i < int'(n)) ? data[i*LANE_W +: LANE_W] : {LANE_W{fill}};
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer splitting DATA_W accesses into LANE_W RAM beats
// Optional MISALIGN_TRAP_EN: misaligned or illegal-size requests return rsp_err without RAM access.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LANE_W     = 8,
    parameter int ADDR_W     = 32,
    parameter int MEM_ADDR_W = 15,
    parameter int RD_LAT     = 1,
    localparam int NL   = DATA_W / LANE_W,
    localparam int LG   = $clog2(NL),
    localparam int CW   = LG + 1,
    localparam int SZ_W = sz_w(NL)
) (
    input  logic                  clock,
    input  logic                  db_clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [SZ_W-1:0]       req_size,
    input  logic                  req_sext,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [LANE_W-1:0]     mem_data,
    output logic                  mem_wren,
    input  logic [LANE_W-1:0]     mem_q
);
    state_t state;
    logic [CW-1:0] n, n_req, icnt, rcnt;
    logic we, sext, legal, err, cap, last;
    logic [DATA_W-1:0] wbuf, rbuf, buf_nxt, ext;
    logic [RD_LAT-1:0] pipe;
    assign req_ready = (state == IDLE) && !db_clear;
    assign legal = int'(req_size) <= LG;
    assign n_req = legal ? CW'(1) << req_size : CW'(NL);
`ifdef MISALIGN_TRAP_EN
    assign err = !legal || ((req_addr & ADDR_W'(n_req - 1'b1)) != '0);
`else
    logic unused_addr;
    assign unused_addr = ^req_addr;
    assign err = 1'b0;
`endif
    // pipe tracks issued read beats so each lane is captured exactly RD_LAT cycles later
    assign cap = pipe[RD_LAT-1];
    assign last = cap && (rcnt == n - 1'b1);
    always_comb begin
        buf_nxt = rbuf;
        buf_nxt[int'(rcnt)*LANE_W +: LANE_W] = mem_q;
    end
    lane_extend #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_ext (
        .data(buf_nxt), .n(n), .sext(sext), .ext(ext)
    );
    always_ff @(posedge clock) begin
        if (db_clear) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_data  <= '0;
            mem_wren  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            pipe      <= '0;
        end else begin
            pipe <= RD_LAT'({pipe, (state == ISSUE) && !we});
            if (cap) begin
                rbuf <= buf_nxt;
                rcnt <= rcnt + 1'b1;
            end
            case (state)
                IDLE: if (req_valid) begin
                    n    <= n_req;
                    we   <= req_we;
                    sext <= req_sext;
                    rcnt <= '0;
                    icnt <= CW'(1);
                    wbuf <= req_wdata >> LANE_W;
                    if (err) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        state    <= ISSUE;
                        mem_addr <= req_addr[MEM_ADDR_W-1:0];
                        mem_wren <= req_we;
                        mem_data <= req_wdata[LANE_W-1:0];
                    end
                end
                ISSUE: if (icnt == n) begin
                    mem_addr  <= '0;
                    mem_data  <= '0;
                    mem_wren  <= 1'b0;
                    state     <= we ? RESP : DRAIN;
                    rsp_valid <= we;
                    rsp_rdata <= '0;
                end else begin
                    mem_addr <= mem_addr + 1'b1;
                    mem_data <= wbuf[LANE_W-1:0];
                    wbuf     <= wbuf >> LANE_W;
                    icnt     <= icnt + 1'b1;
                end
                DRAIN: if (last) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ext;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a behavioural byte RAM
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic db_clear, req_valid, req_ready, req_we, req_sext, rsp_valid, rsp_ready, rsp_err, mem_wren;
    logic [1:0] req_size;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [14:0] mem_addr, pl_addr;
    logic [7:0] mem_data, mem_q, pl_data;
    logic pl_en;
    logic [7:0] ram [0:32767];
    int checks = 0, errors = 0, c;

    mem_access_unit dut (
        .clock(clock), .db_clear(db_clear), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always @(posedge clock) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_wren) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [14:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_we = we; req_size = size; req_sext = sext; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (!rsp_valid && cyc < 50) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        db_clear = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_sext = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wren", 32'(mem_wren), 0);
        check("rst_mem_data", 32'(mem_data), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        db_clear = 1'b0;
        #1;
        check("rel_req_ready", 32'(req_ready), 1);
        step();
        preload(15'h10, 8'h78); preload(15'h11, 8'h56); preload(15'h12, 8'h34); preload(15'h13, 8'h12);
        preload(15'h21, 8'h80); preload(15'h22, 8'h01); preload(15'h23, 8'h80);
        preload(15'h40, 8'h5A); preload(15'h51, 8'h00); preload(15'h03, 8'h9A); preload(15'h04, 8'hBC);

        // word load: addresses in cycles 1-4, response in cycle 6
        issue(1'b0, 2'(SIZE_WORD), 1'b0, 32'h10, 0);
        check("wl_addr_c1", 32'(mem_addr), 32'h10);
        step(); check("wl_addr_c2", 32'(mem_addr), 32'h11);
        step(); check("wl_addr_c3", 32'(mem_addr), 32'h12);
        step(); check("wl_addr_c4", 32'(mem_addr), 32'h13);
        check("wl_wren", 32'(mem_wren), 0);
        step(); check("wl_addr_c5", 32'(mem_addr), 0);
        check("wl_valid_c5", 32'(rsp_valid), 0);
        step(); check("wl_valid_c6", 32'(rsp_valid), 1);
        check("wl_rdata", rsp_rdata, 32'h12345678);
        check("wl_busy", 32'(req_ready), 0);
        step(); check("wl_idle", 32'(req_ready), 1);
        check("wl_valid_drop", 32'(rsp_valid), 0);

        issue(1'b0, 2'(SIZE_BYTE), 1'b1, 32'h21, 0);
        wait_rsp(c); check("bl_sext_cyc", c, 3); check("bl_sext", rsp_rdata, 32'hFFFFFF80);
        step();
        issue(1'b0, 2'(SIZE_BYTE), 1'b0, 32'h21, 0);
        wait_rsp(c); check("bl_zext", rsp_rdata, 32'h00000080);
        step();
        issue(1'b0, 2'(SIZE_HALF), 1'b1, 32'h22, 0);
        wait_rsp(c); check("hl_cyc", c, 4); check("hl_sext", rsp_rdata, 32'hFFFF8001);
        step();

        // word store wrapping past the top of the 15-bit RAM
        issue(1'b1, 2'(SIZE_WORD), 1'b0, 32'h7FFE, 32'hDEADBEEF);
        check("ws_a1", 32'(mem_addr), 32'h7FFE); check("ws_d1", 32'(mem_data), 32'hEF); check("ws_w1", 32'(mem_wren), 1);
        step(); check("ws_a2", 32'(mem_addr), 32'h7FFF); check("ws_d2", 32'(mem_data), 32'hBE);
        step(); check("ws_a3", 32'(mem_addr), 32'h0000); check("ws_d3", 32'(mem_data), 32'hAD);
        step(); check("ws_a4", 32'(mem_addr), 32'h0001); check("ws_d4", 32'(mem_data), 32'hDE);
        step(); check("ws_valid_c5", 32'(rsp_valid), 1); check("ws_rdata", rsp_rdata, 0);
        check("ws_wren_off", 32'(mem_wren), 0);
        step();
        check("ws_ram0", 32'(ram[15'h7FFE]), 32'hEF); check("ws_ram1", 32'(ram[15'h7FFF]), 32'hBE);
        check("ws_ram2", 32'(ram[15'h0000]), 32'hAD); check("ws_ram3", 32'(ram[15'h0001]), 32'hDE);

        // back-pressure: response held, competing request ignored
        rsp_ready = 1'b0;
        issue(1'b0, 2'(SIZE_WORD), 1'b0, 32'h10, 0);
        wait_rsp(c); check("bp_cyc", c, 6);
        req_we = 1'b1; req_size = 2'(SIZE_BYTE); req_addr = 32'h40; req_wdata = 32'hA5; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_rdata", rsp_rdata, 32'h12345678);
            check("bp_ready", 32'(req_ready), 0);
            check("bp_wren", 32'(mem_wren), 0);
            step();
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        step(); check("bp_idle", 32'(req_ready), 1); check("bp_valid_drop", 32'(rsp_valid), 0);
        step(); check("bp_wren_after", 32'(mem_wren), 0); check("bp_ram40", 32'(ram[15'h40]), 32'h5A);

        // abort a word store after lane 0
        issue(1'b1, 2'(SIZE_WORD), 1'b0, 32'h50, 32'h11223344);
        check("ab_w1", 32'(mem_wren), 1);
        db_clear = 1'b1;
        step(); check("ab_wren", 32'(mem_wren), 0); check("ab_addr", 32'(mem_addr), 0);
        check("ab_ready_clr", 32'(req_ready), 0);
        db_clear = 1'b0;
        #1; check("ab_ready_rel", 32'(req_ready), 1);
        for (int i = 0; i < 4; i++) begin
            step(); check("ab_no_rsp", 32'(rsp_valid), 0); check("ab_no_wren", 32'(mem_wren), 0);
        end
        check("ab_ram50", 32'(ram[15'h50]), 32'h44); check("ab_ram51", 32'(ram[15'h51]), 32'h00);

        // misaligned half load and illegal size
        issue(1'b0, 2'(SIZE_HALF), 1'b0, 32'h3, 0);
`ifdef MISALIGN_TRAP_EN
        check("mis_valid_c1", 32'(rsp_valid), 1); check("mis_err", 32'(rsp_err), 1);
        check("mis_rdata", rsp_rdata, 0); check("mis_addr", 32'(mem_addr), 0);
        step();
        issue(1'b0, 2'd3, 1'b0, 32'h10, 0);
        check("ill_valid_c1", 32'(rsp_valid), 1); check("ill_err", 32'(rsp_err), 1);
        check("ill_rdata", rsp_rdata, 0);
        step();
`else
        check("mis_a1", 32'(mem_addr), 32'h3);
        step(); check("mis_a2", 32'(mem_addr), 32'h4);
        wait_rsp(c); check("mis_cyc", c, 3);
        check("mis_rdata", rsp_rdata, 32'h0000BC9A); check("mis_err", 32'(rsp_err), 0);
        step();
        issue(1'b0, 2'd3, 1'b0, 32'h10, 0);
        wait_rsp(c); check("ill_cyc", c, 6);
        check("ill_rdata", rsp_rdata, 32'h12345678); check("ill_err", 32'(rsp_err), 0);
        step();
`endif
        check("end_idle", 32'(req_ready), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
